// File: rtl/invader_shot_scheduler_if.sv
// Muzzle-position handshake between the shot scheduler (master) and the invader block (slave).
// The master holds spawn_req/spawn_col until the slave answers with spawn_ack and a position.
interface invader_shot_scheduler_if;
    logic       spawn_req;
    logic [3:0] spawn_col;
    logic       spawn_ack;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;

    modport master (output spawn_req, output spawn_col,
                    input  spawn_ack, input  spawn_x, input  spawn_y);
    modport slave  (input  spawn_req, input  spawn_col,
                    output spawn_ack, output spawn_x, output spawn_y);
endinterface

// File: rtl/invader_shot_scheduler.sv
// Invader shot scheduler: periodic LFSR column pick, muzzle-position request,
// and per-frame movement / clearing of a small pool of downward shots.
module invader_shot_scheduler #(
    parameter int unsigned NUM_SHOTS     = 3,
    parameter int unsigned NUM_COLS      = 11,
    parameter int unsigned FIRE_PERIOD   = 48,
    parameter int unsigned SHOT_STEP     = 4,
    parameter int unsigned SCREEN_BOTTOM = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      game_active,
    input  logic [NUM_COLS-1:0]       col_alive,
    invader_shot_scheduler_if.master  spawn,
    input  logic [NUM_SHOTS-1:0]      shot_hit,
    output logic [NUM_SHOTS-1:0]      shot_active,
    output logic [10*NUM_SHOTS-1:0]   shot_x,
    output logic [10*NUM_SHOTS-1:0]   shot_y
);
    localparam int unsigned CW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FIRE_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT} state_t;

    state_t               state;
    logic [7:0]           lfsr;
    logic [CW-1:0]        frame_cnt;
    logic                 fire_tick;
    logic [3:0]           col;
    logic [3:0]           scan_count;
    logic [3:0]           cand;
    logic [3:0]           col_next;
    logic                 spawn_load;
    logic [NUM_SHOTS-1:0] load_mask;
    logic [NUM_SHOTS-1:0] exits;
    logic [10:0]          y_adv [NUM_SHOTS];

    assign cand = ({1'b0, lfsr[3:0]} >= 5'(NUM_COLS)) ? lfsr[3:0] - 4'(NUM_COLS) : lfsr[3:0];
    assign col_next = (col == 4'(NUM_COLS - 1)) ? '0 : col + 4'd1;
    assign spawn_load = (state == WAIT) && spawn.spawn_ack && game_active;
    // Lowest clear bit of shot_active: the lowest-index free slot, empty when all are busy.
    assign load_mask = ~shot_active & (shot_active + NUM_SHOTS'(1));

    always_comb begin
        exits = '0;
        for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
            y_adv[i] = {1'b0, shot_y[10*i +: 10]} + 11'(SHOT_STEP);
            exits[i] = (y_adv[i] >= 11'(SCREEN_BOTTOM));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lfsr             <= 8'hA5;
            frame_cnt        <= '0;
            fire_tick        <= 1'b0;
            col              <= '0;
            scan_count       <= '0;
            spawn.spawn_req  <= 1'b0;
            spawn.spawn_col  <= '0;
        end else begin
            if (frame && game_active) begin
                lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CW'(1);
            end
            fire_tick <= frame && game_active && (frame_cnt == LAST_CNT);

            if (!game_active) begin
                state           <= IDLE;
                spawn.spawn_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (fire_tick && !(&shot_active) && (|col_alive)) begin
                            col        <= cand;
                            scan_count <= '0;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (col_alive[col]) begin
                            state <= REQ;
                        end else begin
                            col        <= col_next;
                            scan_count <= scan_count + 4'd1;
                            if (scan_count == 4'(NUM_COLS - 1))
                                state <= IDLE;
                        end
                    end
                    REQ: begin
                        spawn.spawn_req <= 1'b1;
                        spawn.spawn_col <= col;
                        state           <= WAIT;
                    end
                    WAIT: begin
                        if (spawn.spawn_ack) begin
                            spawn.spawn_req <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Per slot: hit beats spawn beats frame move; a fresh spawn is not moved by a coincident frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shot_active <= '0;
            shot_x      <= '0;
            shot_y      <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
                if (!game_active || shot_hit[i]) begin
                    shot_active[i] <= 1'b0;
                end else if (spawn_load && load_mask[i]) begin
                    shot_active[i]     <= 1'b1;
                    shot_x[10*i +: 10] <= spawn.spawn_x;
                    shot_y[10*i +: 10] <= spawn.spawn_y;
                end else if (frame && shot_active[i]) begin
                    if (exits[i])
                        shot_active[i] <= 1'b0;
                    else
                        shot_y[10*i +: 10] <= y_adv[i][9:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_invader_shot_scheduler.sv
// Bench for invader_shot_scheduler: directed scenarios plus randomized fire/hit traffic,
// checked against a transaction-level model of slots, LFSR and frame counter.
module tb_invader_shot_scheduler;
    localparam int NS = 3, NC = 11, FP = 16, STEP = 4, BOT = 480;

    logic          clk = 1'b0;
    logic          rst, frame, game_active;
    logic [NC-1:0] col_alive;
    logic [NS-1:0] shot_hit;
    logic [NS-1:0] shot_active;
    logic [10*NS-1:0] shot_x, shot_y;

    invader_shot_scheduler_if bus ();

    invader_shot_scheduler #(
        .NUM_SHOTS(NS), .NUM_COLS(NC), .FIRE_PERIOD(FP),
        .SHOT_STEP(STEP), .SCREEN_BOTTOM(BOT)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .game_active(game_active),
        .col_alive(col_alive), .spawn(bus.master), .shot_hit(shot_hit),
        .shot_active(shot_active), .shot_x(shot_x), .shot_y(shot_y)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_checks = 0;

    bit m_act [NS];
    int m_x [NS];
    int m_y [NS];
    int m_lfsr, m_cnt;
    bit m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    function automatic int cand_of(input int v);
        int c;
        c = v % 16;
        return (c >= NC) ? c - NC : c;
    endfunction

    function automatic bit all_full();
        for (int i = 0; i < NS; i++) if (!m_act[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_lfsr = 8'hA5; m_cnt = 0; m_tick = 0;
        for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    endtask

    task automatic model_cycle(input bit fr, input logic [NS-1:0] hit, input bit ack, input int x, input int y);
        int tgt;
        tgt = -1;
        for (int i = 0; i < NS; i++) if (!m_act[i] && tgt < 0) tgt = i;
        for (int i = 0; i < NS; i++) begin
            if (!game_active || hit[i]) m_act[i] = 0;
            else if (ack && i == tgt) begin m_act[i] = 1; m_x[i] = x; m_y[i] = y; end
            else if (fr && m_act[i]) begin
                if (m_y[i] + STEP >= BOT) m_act[i] = 0;
                else m_y[i] = m_y[i] + STEP;
            end
        end
        if (fr && game_active) begin
            m_lfsr = lfsr_next(m_lfsr);
            if (m_cnt == FP - 1) begin m_cnt = 0; m_tick = 1; end
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic drive_cycle(input bit fr, input logic [NS-1:0] hit, input bit ack, input int x, input int y);
        @(negedge clk);
        frame = fr; shot_hit = hit; bus.spawn_ack = ack;
        bus.spawn_x = 10'(x); bus.spawn_y = 10'(y);
        model_cycle(fr, hit, ack, x, y);
        @(negedge clk);
        frame = 0; shot_hit = '0; bus.spawn_ack = 0;
    endtask

    task automatic frame_step(input logic [NS-1:0] hit);
        drive_cycle(1'b1, hit, 1'b0, 0, 0);
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < NS; i++) begin
            chk({tag, "_active"}, 32'(shot_active[i]), 32'(m_act[i]));
            if (m_act[i]) begin
                chk({tag, "_x"}, 32'(shot_x[10*i +: 10]), 32'(m_x[i]));
                chk({tag, "_y"}, 32'(shot_y[10*i +: 10]), 32'(m_y[i]));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, 32'(bus.spawn_req), 0);
        chk({tag, "_col"}, 32'(bus.spawn_col), 0);
        chk({tag, "_active"}, 32'(shot_active), 0);
        chk({tag, "_x"}, 32'(shot_x), 0);
        chk({tag, "_y"}, 32'(shot_y), 0);
    endtask

    task automatic advance_to_tick(input bit rnd_hits);
        logic [NS-1:0] h;
        int guard;
        guard = 0;
        while (!m_tick && guard < FP + 2) begin
            h = '0;
            if (rnd_hits && ($urandom % 16 == 0)) h[$urandom_range(0, NS - 1)] = 1'b1;
            frame_step(h);
            guard++;
        end
    endtask

    // Leaves the bench at a negedge with the DUT in WAIT when do_ack=0 and a request was expected.
    task automatic serve_tick(input bit do_ack, input int x, input int y, input int stall);
        int cand, col, d, lat;
        bit seen, unstable;
        logic [3:0] held_col;
        m_tick = 0;
        if (all_full() || col_alive == '0) begin
            seen = 0;
            repeat (12) begin @(negedge clk); if (bus.spawn_req) seen = 1; end
            chk("no_request", 32'(seen), 0);
            return;
        end
        cand = cand_of(m_lfsr);
        col = -1; d = 0;
        for (int k = 0; k < NC && col < 0; k++)
            if (col_alive[(cand + k) % NC]) begin col = (cand + k) % NC; d = k; end
        lat = 0;
        while (!bus.spawn_req && lat < 40) begin @(negedge clk); lat++; end
        chk("req_latency", 32'(lat), 32'(3 + d));
        chk("spawn_col", 32'(bus.spawn_col), 32'(col));
        if (stall > 0) begin
            unstable = 0; held_col = bus.spawn_col;
            repeat (stall) begin
                @(negedge clk);
                if (!bus.spawn_req || bus.spawn_col !== held_col) unstable = 1;
            end
            chk("wait_stable", 32'(unstable), 0);
        end
        if (do_ack) begin
            drive_cycle(1'b0, '0, 1'b1, x, y);
            chk("req_drop", 32'(bus.spawn_req), 0);
            check_slots("after_ack");
        end
    endtask

    task automatic clear_slots();
        drive_cycle(1'b0, '1, 1'b0, 0, 0);
        check_slots("hit_clear");
    endtask

    initial begin
        int target, nl;
        rst = 1; frame = 0; game_active = 0; col_alive = '0; shot_hit = '0;
        bus.spawn_ack = 0; bus.spawn_x = '0; bus.spawn_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0; game_active = 1; col_alive = '1;

        // First fire tick after FP frames, ack (100,200) into slot0.
        advance_to_tick(1'b0);
        serve_tick(1'b1, 100, 200, 0);
        chk("first_slot0_x", 32'(shot_x[9:0]), 100);
        chk("first_slot0_y", 32'(shot_y[9:0]), 200);
        repeat (5) frame_step('0);
        chk("move5_y", 32'(shot_y[9:0]), 220);
        check_slots("move5");

        // Shot loaded at y=476 leaves the screen on the next frame.
        advance_to_tick(1'b0);
        serve_tick(1'b1, 300, 476, 0);
        frame_step('0);
        chk("bottom_exit", 32'(shot_active[1]), 0);
        check_slots("bottom");

        // Forced scan: only column (candidate+4) alive.
        clear_slots();
        while (m_cnt != FP - 1) frame_step('0);
        nl = lfsr_next(m_lfsr);
        target = (cand_of(nl) + 4) % NC;
        col_alive = '0; col_alive[target] = 1'b1;
        frame_step('0);
        serve_tick(1'b1, 10, 20, 0);

        // No live columns: tick dropped.
        col_alive = '0;
        advance_to_tick(1'b0);
        serve_tick(1'b1, 0, 0, 0);

        // Fill all slots, full tick dropped, hit frees slot1, next tick refills slot1.
        col_alive = '1;
        clear_slots();
        for (int t = 0; t < NS; t++) begin
            advance_to_tick(1'b0);
            serve_tick(1'b1, $urandom_range(0, 639), $urandom_range(0, 40), 0);
        end
        chk("full_active", 32'(shot_active), 32'((1 << NS) - 1));
        advance_to_tick(1'b0);
        serve_tick(1'b1, 1, 1, 0);
        drive_cycle(1'b0, 3'b010, 1'b0, 0, 0);
        chk("hit_slot1", 32'(shot_active), 32'b101);
        advance_to_tick(1'b0);
        serve_tick(1'b1, 222, 33, 0);
        chk("refill_slot1_y", 32'(shot_y[19:10]), 33);

        // Frame + ack + hit[0] in one cycle with slot1 at y=100.
        clear_slots();
        advance_to_tick(1'b0);
        serve_tick(1'b1, 40, 30, 0);
        advance_to_tick(1'b0);
        serve_tick(1'b1, 50, 100 - STEP * FP, 0);
        advance_to_tick(1'b0);
        serve_tick(1'b0, 0, 0, 0);
        drive_cycle(1'b1, 3'b001, 1'b1, 55, 77);
        chk("combo_slot0_off", 32'(shot_active[0]), 0);
        chk("combo_slot1_y", 32'(shot_y[19:10]), 104);
        chk("combo_slot2_y", 32'(shot_y[29:20]), 77);
        chk("combo_req_drop", 32'(bus.spawn_req), 0);
        check_slots("combo");

        // Randomized traffic.
        for (int t = 0; t < 12; t++) begin
            if ($urandom % 6 == 0) col_alive = '0;
            else if ($urandom % 3 == 0) begin col_alive = '0; col_alive[$urandom_range(0, NC - 1)] = 1'b1; end
            else col_alive = NC'($urandom) | NC'(1 << $urandom_range(0, NC - 1));
            advance_to_tick(1'b1);
            serve_tick(1'b1, $urandom_range(0, 639),
                       ($urandom % 5 == 0) ? $urandom_range(440, 479) : $urandom_range(0, 40),
                       $urandom_range(0, 4));
            check_slots("rand");
        end

        // game_active low while waiting: slots cleared, request dropped, counter/LFSR hold.
        col_alive = '1;
        clear_slots();
        advance_to_tick(1'b0);
        serve_tick(1'b0, 0, 0, 5);
        @(negedge clk);
        game_active = 0;
        frame = 1;
        model_cycle(1'b1, '0, 1'b0, 0, 0);
        @(negedge clk);
        frame = 0;
        chk("inactive_req", 32'(bus.spawn_req), 0);
        chk("inactive_slots", 32'(shot_active), 0);
        game_active = 1;
        advance_to_tick(1'b0);
        serve_tick(1'b1, 7, 8, 0);

        // Long stall in WAIT, then reset abandons the request.
        advance_to_tick(1'b0);
        serve_tick(1'b0, 0, 0, 20);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
